// File: rtl/life_mem_scheduler.sv
// life_mem_scheduler
//   Shares the single-port cell-state RAM between the VGA display fetch and the
//   Game of Life update engine, and schedules one generation every GEN_DIV
//   frames (or on a single-step request). The display always wins the RAM.
//   Generations are launched only on a frame boundary.
//
//   Handshake: disp_req/eng_req are requests, eng_gnt says the engine owns
//   the RAM in the same cycle; the engine keeps eng_req (and its address,
//   write-enable and data) stable until it sees eng_gnt=1. A granted read
//   returns eng_rvalid/eng_rdata exactly one cycle later; a display access
//   returns disp_rvalid/disp_rdata one cycle later. Writes return nothing.
module life_mem_scheduler #(
  parameter int ADDR_W  = 11,
  parameter int GEN_DIV = 8,
  parameter int GEN_W   = 16
) (
  input  logic              pixel_clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              run_en,
  input  logic              step,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_rvalid,
  output logic              disp_rdata,
  input  logic              eng_req,
  input  logic              eng_we,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic              eng_wdata,
  output logic              eng_gnt,
  output logic              eng_rvalid,
  output logic              eng_rdata,
  input  logic              eng_done,
  output logic              gen_start,
  output logic              busy,
  output logic              overrun,
  output logic [GEN_W-1:0]  gen_count,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wdata,
  input  logic              ram_rdata,
  output logic              state_dbg
);

  // Frame counter is at least one bit wide so GEN_DIV=1 still elaborates.
  localparam int CNT_W = (GEN_DIV > 1) ? $clog2(GEN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(GEN_DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state, state_next;
  logic [CNT_W-1:0] frame_cnt, frame_cnt_next;
  logic             step_pend, step_pend_next;
  logic             gen_start_next;
  logic             overrun_next;
  logic [GEN_W-1:0] gen_count_next;

  // Fixed-priority RAM mux: display first, engine gets whatever is left.
  always_comb begin
    ram_en    = disp_req | eng_req;
    eng_gnt   = 1'b0;
    ram_addr  = disp_addr;
    ram_we    = 1'b0;
    ram_wdata = 1'b0;
    if (!disp_req) begin
      eng_gnt   = eng_req;
      ram_addr  = eng_addr;
      ram_we    = eng_we & eng_req;
      ram_wdata = eng_wdata;
    end
  end

  // Read-return valids track the RAM's one-cycle read latency.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_rvalid <= 1'b0;
      eng_rvalid  <= 1'b0;
    end else begin
      disp_rvalid <= disp_req;
      eng_rvalid  <= eng_gnt & ~eng_we;
    end
  end

  // Read data comes straight from the RAM; the valids say who owns it.
  assign disp_rdata = ram_rdata;
  assign eng_rdata  = ram_rdata;

  // Scheduler state register.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      frame_cnt <= '0;
      step_pend <= 1'b0;
      gen_start <= 1'b0;
      overrun   <= 1'b0;
      gen_count <= '0;
    end else begin
      state     <= state_next;
      frame_cnt <= frame_cnt_next;
      step_pend <= step_pend_next;
      gen_start <= gen_start_next;
      overrun   <= overrun_next;
      gen_count <= gen_count_next;
    end
  end

  // Scheduler next-state: frame pacing, step latching, launch and completion.
  always_comb begin
    state_next     = state;
    frame_cnt_next = frame_cnt;
    step_pend_next = step_pend | step;
    gen_start_next = 1'b0;
    overrun_next   = overrun;
    gen_count_next = gen_count;
    case (state)
      IDLE: begin
        if (!run_en) begin
          frame_cnt_next = '0;
        end else if (frame_start) begin
          frame_cnt_next = (frame_cnt == CNT_MAX) ? '0 : frame_cnt + 1'b1;
        end
        if (frame_start && ((run_en && frame_cnt == CNT_MAX) || step_pend)) begin
          state_next     = RUN;
          gen_start_next = 1'b1;
          step_pend_next = 1'b0;
        end
      end
      RUN: begin
        // The frame count is frozen while a generation runs.
        if (!run_en) frame_cnt_next = '0;
        if (eng_done) begin
          gen_count_next = gen_count + 1'b1;
          state_next     = IDLE;
        end else if (frame_start) begin
          overrun_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy      = (state == RUN);
  assign state_dbg = state;

endmodule
